// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: shares one AXI4-Lite slave port between the instruction-fetch master (read-only)
//   and the load/store master (read/write). Only one transaction is in flight at a time.
// Latency: a request seen in IDLE in cycle N drives the slave-side valid from cycle N+1.
//   Responses pass combinationally back to the owning master.
// Backpressure: the master-side readys mirror the slave readys for the granted master only. No master-side
//   ready is asserted in IDLE, and the grant is held until the response handshake completes.
// Ports: clk/rst (async, active-low); if_* = IF read master; ls_* = LSU read/write master;
//   s_* = slave port; grant = one-hot owner ([0]=IF, [1]=LSU); busy = not IDLE.
// Optional macro AXI_ARB_ROUND_ROBIN_EN: round-robin priority between IF and LSU, based on the last
//   master to complete. When the macro is undefined, priority is fixed: LSU write > LSU read > IF read.
module axi_lite_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  // IF read master
  input  logic            if_arvalid,
  output logic            if_arready,
  input  logic [AW-1:0]   if_araddr,
  output logic            if_rvalid,
  input  logic            if_rready,
  output logic [DW-1:0]   if_rdata,
  output logic [1:0]      if_rresp,
  // LSU read/write master
  input  logic            ls_arvalid,
  output logic            ls_arready,
  input  logic [AW-1:0]   ls_araddr,
  output logic            ls_rvalid,
  input  logic            ls_rready,
  output logic [DW-1:0]   ls_rdata,
  output logic [1:0]      ls_rresp,
  input  logic            ls_awvalid,
  output logic            ls_awready,
  input  logic [AW-1:0]   ls_awaddr,
  input  logic            ls_wvalid,
  output logic            ls_wready,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_wstrb,
  output logic            ls_bvalid,
  input  logic            ls_bready,
  output logic [1:0]      ls_bresp,
  // slave port
  output logic            s_arvalid,
  output logic [AW-1:0]   s_araddr,
  input  logic            s_arready,
  input  logic            s_rvalid,
  input  logic [DW-1:0]   s_rdata,
  input  logic [1:0]      s_rresp,
  output logic            s_rready,
  output logic            s_awvalid,
  output logic [AW-1:0]   s_awaddr,
  input  logic            s_awready,
  output logic            s_wvalid,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_wstrb,
  input  logic            s_wready,
  input  logic            s_bvalid,
  input  logic [1:0]      s_bresp,
  output logic            s_bready,
  // status
  output logic [1:0]      grant,
  output logic            busy
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} state_t;

  state_t     state, state_nxt;
  logic [1:0] grant_nxt;
  logic       wr_aw_done, wr_w_done, aw_done_nxt, w_done_nxt;
  logic       ls_wr_req, ls_req, pick_ls;
  logic       aw_hs, w_hs;

`ifdef AXI_ARB_ROUND_ROBIN_EN
  logic last_grant, last_grant_nxt;  // 0 = IF completed last, 1 = LSU completed last
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= 2'b00;
      wr_aw_done <= 1'b0;
      wr_w_done  <= 1'b0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      wr_aw_done <= aw_done_nxt;
      wr_w_done  <= w_done_nxt;
`ifdef AXI_ARB_ROUND_ROBIN_EN
      last_grant <= last_grant_nxt;
`endif
    end
  end

  assign ls_wr_req = ls_awvalid & ls_wvalid;
  assign ls_req    = ls_wr_req | ls_arvalid;
`ifdef AXI_ARB_ROUND_ROBIN_EN
  // A tie goes to whichever master did not complete last.
  assign pick_ls   = ls_req & ~(if_arvalid & last_grant);
`else
  assign pick_ls   = ls_req;
`endif

  // Address and write data are steered regardless of state. Only the valids and readys are gated.
  assign s_araddr = grant[1] ? ls_araddr : if_araddr;
  assign s_awaddr = ls_awaddr;
  assign s_wdata  = ls_wdata;
  assign s_wstrb  = ls_wstrb;
  assign busy     = (state != IDLE);

  // Write-phase handshakes. The done flags mask channels that have already completed.
  assign aw_hs = (state == WADDR) & ls_awvalid & ~wr_aw_done & s_awready;
  assign w_hs  = (state == WADDR) & ls_wvalid  & ~wr_w_done  & s_wready;

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    aw_done_nxt = wr_aw_done;
    w_done_nxt  = wr_w_done;
`ifdef AXI_ARB_ROUND_ROBIN_EN
    last_grant_nxt = last_grant;
`endif
    if_arready = 1'b0;  if_rvalid = 1'b0;  if_rdata = '0;  if_rresp = 2'b00;
    ls_arready = 1'b0;  ls_rvalid = 1'b0;  ls_rdata = '0;  ls_rresp = 2'b00;
    ls_awready = 1'b0;  ls_wready = 1'b0;  ls_bvalid = 1'b0;  ls_bresp = 2'b00;
    s_arvalid  = 1'b0;  s_rready  = 1'b0;  s_awvalid = 1'b0;  s_wvalid = 1'b0;
    s_bready   = 1'b0;

    case (state)
      IDLE: begin
        if (pick_ls) begin
          grant_nxt = 2'b10;
          state_nxt = ls_wr_req ? WADDR : RADDR;
        end else if (if_arvalid) begin
          grant_nxt = 2'b01;
          state_nxt = RADDR;
        end
      end
      RADDR: begin
        if (grant[1]) begin
          s_arvalid  = ls_arvalid;
          ls_arready = s_arready;
        end else begin
          s_arvalid  = if_arvalid;
          if_arready = s_arready;
        end
        if (s_arvalid && s_arready) state_nxt = RDATA;
      end
      RDATA: begin
        if (grant[1]) begin
          ls_rvalid = s_rvalid;
          ls_rdata  = s_rdata;
          ls_rresp  = s_rresp;
          s_rready  = ls_rready;
        end else begin
          if_rvalid = s_rvalid;
          if_rdata  = s_rdata;
          if_rresp  = s_rresp;
          s_rready  = if_rready;
        end
        if (s_rvalid && s_rready) begin
          state_nxt = IDLE;
          grant_nxt = 2'b00;
`ifdef AXI_ARB_ROUND_ROBIN_EN
          last_grant_nxt = grant[1];
`endif
        end
      end
      WADDR: begin
        s_awvalid  = ls_awvalid & ~wr_aw_done;
        s_wvalid   = ls_wvalid  & ~wr_w_done;
        ls_awready = s_awready  & ~wr_aw_done;
        ls_wready  = s_wready   & ~wr_w_done;
        // Both channels are complete once each has either finished earlier or handshakes this cycle.
        if ((wr_aw_done | aw_hs) && (wr_w_done | w_hs)) begin
          state_nxt   = WRESP;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end else begin
          aw_done_nxt = wr_aw_done | aw_hs;
          w_done_nxt  = wr_w_done  | w_hs;
        end
      end
      WRESP: begin
        ls_bvalid = s_bvalid;
        ls_bresp  = s_bresp;
        s_bready  = ls_bready;
        if (s_bvalid && s_bready) begin
          state_nxt = IDLE;
          grant_nxt = 2'b00;
`ifdef AXI_ARB_ROUND_ROBIN_EN
          last_grant_nxt = 1'b1;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
module tb_axi_lite_arbiter;
  localparam int TMO = 400;

  logic clk, rst;
  logic if_arvalid, if_arready, if_rvalid, if_rready;
  logic [31:0] if_araddr, if_rdata;
  logic [1:0] if_rresp;
  logic ls_arvalid, ls_arready, ls_rvalid, ls_rready;
  logic [31:0] ls_araddr, ls_rdata;
  logic [1:0] ls_rresp;
  logic ls_awvalid, ls_awready, ls_wvalid, ls_wready, ls_bvalid, ls_bready;
  logic [31:0] ls_awaddr, ls_wdata;
  logic [3:0] ls_wstrb;
  logic [1:0] ls_bresp;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_araddr, s_rdata;
  logic [1:0] s_rresp;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0] s_wstrb;
  logic [1:0] s_bresp;
  logic [1:0] grant;
  logic busy;

  axi_lite_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .if_arvalid(if_arvalid), .if_arready(if_arready), .if_araddr(if_araddr),
    .if_rvalid(if_rvalid), .if_rready(if_rready), .if_rdata(if_rdata), .if_rresp(if_rresp),
    .ls_arvalid(ls_arvalid), .ls_arready(ls_arready), .ls_araddr(ls_araddr),
    .ls_rvalid(ls_rvalid), .ls_rready(ls_rready), .ls_rdata(ls_rdata), .ls_rresp(ls_rresp),
    .ls_awvalid(ls_awvalid), .ls_awready(ls_awready), .ls_awaddr(ls_awaddr),
    .ls_wvalid(ls_wvalid), .ls_wready(ls_wready), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
    .ls_bvalid(ls_bvalid), .ls_bready(ls_bready), .ls_bresp(ls_bresp),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int slave_mode = 0;  // 0 always ready, 1 random, 2 wready two cycles before awready, 3 read data withheld
  bit rnd_rdy = 0;

  // Scoreboard queues, filled when stimulus is issued.
  logic [33:0] exp_if_r[$];
  logic [33:0] exp_ls_r[$];
  logic [31:0] exp_sar_if[$];
  logic [31:0] exp_sar_ls[$];
  logic [31:0] exp_saw[$];
  logic [35:0] exp_sw[$];
  logic [1:0]  exp_ls_b[$];
  logic [31:0] order_log[$];

  int cnt_wrdy, cnt_awrdy, cnt_swv, cnt_sawv, cnt_b;
  int b_cyc, ar_first;

  // Slave contents: read data and error responses depend only on the address.
  function automatic logic [31:0] f_rdata(input logic [31:0] a);
    return a ^ 32'h8000_0013;
  endfunction
  function automatic logic [1:0] f_resp(input logic [31:0] a);
    return (a[31:28] == 4'hE) ? 2'b10 : 2'b00;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // ---------------- slave model ----------------
  initial begin : slave
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, awv;
    logic [31:0] a, awa, rd_addr, wr_addr;
    bit rd_pend, aw_got, w_got, b_pend;
    int r_wait, b_wait, aw_seen;
    rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0; r_wait = 0; b_wait = 0; aw_seen = 0;
    rd_addr = '0; wr_addr = '0;
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
    forever begin
      @(negedge clk);
      ar_hs = s_arvalid && s_arready;  a = s_araddr;
      r_hs  = s_rvalid && s_rready;
      aw_hs = s_awvalid && s_awready;  awa = s_awaddr;
      w_hs  = s_wvalid && s_wready;
      b_hs  = s_bvalid && s_bready;
      awv   = s_awvalid;
      @(posedge clk); #1;
      if (!rst) begin
        rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0; aw_seen = 0;
        s_rvalid = 0; s_bvalid = 0;
        s_arready = 1; s_awready = 1; s_wready = 1;
        continue;
      end
      if (r_hs) s_rvalid = 0;
      if (b_hs) s_bvalid = 0;
      if (ar_hs) begin
        rd_pend = 1; rd_addr = a;
        r_wait = (slave_mode == 1) ? $urandom_range(3, 0) : ((slave_mode == 3) ? 1000000 : 0);
      end
      if (rd_pend) begin
        if (r_wait == 0) begin
          s_rvalid = 1; s_rdata = f_rdata(rd_addr); s_rresp = f_resp(rd_addr); rd_pend = 0;
        end else r_wait--;
      end
      if (aw_hs) begin aw_got = 1; wr_addr = awa; end
      if (w_hs) w_got = 1;
      if (aw_got && w_got) begin
        aw_got = 0; w_got = 0; b_pend = 1;
        b_wait = (slave_mode == 1) ? $urandom_range(3, 0) : 0;
      end
      if (b_pend) begin
        if (b_wait == 0) begin
          s_bvalid = 1; s_bresp = f_resp(wr_addr); b_pend = 0;
        end else b_wait--;
      end
      aw_seen = awv ? aw_seen + 1 : 0;
      case (slave_mode)
        1: begin
          s_arready = 1'($urandom_range(1, 0));
          s_awready = 1'($urandom_range(1, 0));
          s_wready  = 1'($urandom_range(1, 0));
        end
        2: begin s_arready = 1; s_wready = 1; s_awready = (aw_seen >= 2); end
        default: begin s_arready = 1; s_awready = 1; s_wready = 1; end
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst) begin
      checks++;
      if (grant == 2'b11) begin failures++; $display("FAIL grant_onehot actual=%b required=01/10/00", grant); end
      chk("busy_vs_grant", busy, grant != 2'b00);
      if (grant != 2'b01) chk("if_isolated", {if_arready, if_rvalid}, 0);
      if (grant != 2'b10) chk("ls_isolated", {ls_arready, ls_rvalid, ls_awready, ls_wready, ls_bvalid}, 0);
      if (if_rvalid && if_rready) begin
        if (exp_if_r.size() == 0) chk("if_r_unexpected", 1, 0);
        else begin e = exp_if_r.pop_front(); chk("if_r_data_resp", {if_rdata, if_rresp}, e); end
      end
      if (ls_rvalid && ls_rready) begin
        if (exp_ls_r.size() == 0) chk("ls_r_unexpected", 1, 0);
        else begin e = exp_ls_r.pop_front(); chk("ls_r_data_resp", {ls_rdata, ls_rresp}, e); end
      end
      if (ls_bvalid && ls_bready) begin
        cnt_b++;
        if (exp_ls_b.size() == 0) chk("ls_b_unexpected", 1, 0);
        else chk("ls_bresp", ls_bresp, exp_ls_b.pop_front());
      end
      if (s_arvalid && s_arready) begin
        order_log.push_back(s_araddr);
        if (grant == 2'b01 && exp_sar_if.size() != 0) chk("s_araddr_if", s_araddr, exp_sar_if.pop_front());
        else if (grant == 2'b10 && exp_sar_ls.size() != 0) chk("s_araddr_ls", s_araddr, exp_sar_ls.pop_front());
        else chk("s_ar_unexpected", 1, 0);
      end
      if (s_awvalid && s_awready) begin
        if (exp_saw.size() == 0) chk("s_aw_unexpected", 1, 0);
        else chk("s_awaddr", s_awaddr, exp_saw.pop_front());
      end
      if (s_wvalid && s_wready) begin
        if (exp_sw.size() == 0) chk("s_w_unexpected", 1, 0);
        else chk("s_wdata_strb", {s_wdata, s_wstrb}, exp_sw.pop_front());
      end
      if (ls_wready) cnt_wrdy++;
      if (ls_awready) cnt_awrdy++;
      if (s_wvalid) cnt_swv++;
      if (s_awvalid) cnt_sawv++;
      if (s_bvalid && s_bready) b_cyc = cyc;
      if (s_arvalid && s_araddr == 32'h500 && ar_first < 0) ar_first = cyc;
    end
  end

  // ---------------- master tasks (start and end at posedge+1) ----------------
  task automatic if_read(input logic [31:0] a);
    bit hs; int n;
    exp_if_r.push_back({f_rdata(a), f_resp(a)});
    exp_sar_if.push_back(a);
    if_arvalid = 1; if_araddr = a; hs = 0; n = 0;
    while (!hs && n < TMO) begin
      @(negedge clk); hs = if_arvalid && if_arready;
      @(posedge clk); #1; n++;
    end
    if_arvalid = 0;
    if (!hs) chk("if_ar_timeout", 0, 1);
    hs = 0; n = 0;
    while (!hs && n < TMO) begin
      if_rready = rnd_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
      @(negedge clk); hs = if_rvalid && if_rready;
      @(posedge clk); #1; n++;
    end
    if_rready = 0;
    if (!hs) chk("if_r_timeout", 0, 1);
  endtask

  task automatic ls_read(input logic [31:0] a);
    bit hs; int n;
    exp_ls_r.push_back({f_rdata(a), f_resp(a)});
    exp_sar_ls.push_back(a);
    ls_arvalid = 1; ls_araddr = a; hs = 0; n = 0;
    while (!hs && n < TMO) begin
      @(negedge clk); hs = ls_arvalid && ls_arready;
      @(posedge clk); #1; n++;
    end
    ls_arvalid = 0;
    if (!hs) chk("ls_ar_timeout", 0, 1);
    hs = 0; n = 0;
    while (!hs && n < TMO) begin
      ls_rready = rnd_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
      @(negedge clk); hs = ls_rvalid && ls_rready;
      @(posedge clk); #1; n++;
    end
    ls_rready = 0;
    if (!hs) chk("ls_r_timeout", 0, 1);
  endtask

  task automatic ls_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ah, wh, ag, wg, hs; int n;
    exp_saw.push_back(a);
    exp_sw.push_back({d, s});
    exp_ls_b.push_back(f_resp(a));
    ls_awvalid = 1; ls_awaddr = a; ls_wvalid = 1; ls_wdata = d; ls_wstrb = s;
    ag = 0; wg = 0; n = 0;
    while (!(ag && wg) && n < TMO) begin
      @(negedge clk); ah = ls_awvalid && ls_awready; wh = ls_wvalid && ls_wready;
      @(posedge clk); #1; n++;
      if (ah) begin ag = 1; ls_awvalid = 0; end
      if (wh) begin wg = 1; ls_wvalid = 0; end
    end
    ls_awvalid = 0; ls_wvalid = 0;
    if (!(ag && wg)) chk("ls_aw_w_timeout", 0, 1);
    hs = 0; n = 0;
    while (!hs && n < TMO) begin
      ls_bready = rnd_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
      @(negedge clk); hs = ls_bvalid && ls_bready;
      @(posedge clk); #1; n++;
    end
    ls_bready = 0;
    if (!hs) chk("ls_b_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit hs; int n;
    logic [31:0] exp_first;
    rst = 0;
    if_arvalid = 0; if_araddr = '0; if_rready = 0;
    ls_arvalid = 0; ls_araddr = '0; ls_rready = 0;
    ls_awvalid = 0; ls_awaddr = '0; ls_wvalid = 0; ls_wdata = '0; ls_wstrb = '0; ls_bready = 0;
    cnt_wrdy = 0; cnt_awrdy = 0; cnt_swv = 0; cnt_sawv = 0; cnt_b = 0; b_cyc = 0; ar_first = -1;

    // Reset state, with requests present so that gating is actually exercised.
    idle(2);
    if_arvalid = 1; ls_arvalid = 1; ls_awvalid = 1; ls_wvalid = 1;
    @(negedge clk);
    chk("rst_grant_busy", {grant, busy}, 0);
    chk("rst_slave_side", {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}, 0);
    chk("rst_master_side", {if_arready, if_rvalid, ls_arready, ls_rvalid, ls_awready, ls_wready, ls_bvalid}, 0);
    @(posedge clk); #1;
    if_arvalid = 0; ls_arvalid = 0; ls_awvalid = 0; ls_wvalid = 0;
    idle(1);
    rst = 1;
    idle(2);

    // Single IF read, cycle by cycle.
    exp_if_r.push_back({32'h0000_0013, 2'b00});
    exp_sar_if.push_back(32'h8000_0000);
    if_arvalid = 1; if_araddr = 32'h8000_0000;
    @(negedge clk);
    chk("t1_no_passthru", {s_arvalid, if_arready, grant}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_s_arvalid", s_arvalid, 1);
    chk("t1_grant", grant, 2'b01);
    chk("t1_s_araddr", s_araddr, 32'h8000_0000);
    chk("t1_if_arready", if_arready, 1);
    @(posedge clk); #1;
    if_arvalid = 0; if_rready = 1;
    @(negedge clk);
    chk("t1_if_rvalid", if_rvalid, 1);
    chk("t1_if_rdata", if_rdata, 32'h13);
    @(posedge clk); #1;
    if_rready = 0;
    @(negedge clk);
    chk("t1_back_idle", {grant, busy}, 0);
    @(posedge clk); #1;

    // LSU read with a slave error response.
    ls_read(32'hE000_0040);
    @(negedge clk);
    chk("t2_idle_after_err", {grant, busy}, 0);
    @(posedge clk); #1;

    // Simultaneous IF and LSU reads; the LSU completed last.
    order_log.delete();
    fork
      if_read(32'h100);
      ls_read(32'h200);
    join
`ifdef AXI_ARB_ROUND_ROBIN_EN
    exp_first = 32'h100;
`else
    exp_first = 32'h200;
`endif
    chk("t3_order_count", order_log.size(), 2);
    if (order_log.size() == 2) begin
      chk("t3_first_served", order_log[0], exp_first);
      chk("t3_second_served", order_log[1], exp_first ^ 32'h300);
    end
    idle(1);

    // Write with W accepted two cycles before AW.
    slave_mode = 2;
    cnt_wrdy = 0; cnt_awrdy = 0; cnt_swv = 0; cnt_sawv = 0; cnt_b = 0;
    ls_write(32'h300, 32'hDEAD_BEEF, 4'hF);
    chk("t4_ls_wready_pulses", cnt_wrdy, 1);
    chk("t4_ls_awready_pulses", cnt_awrdy, 1);
    chk("t4_s_wvalid_cycles", cnt_swv, 1);
    chk("t4_s_awvalid_cycles", cnt_sawv, 3);
    chk("t4_b_count", cnt_b, 1);
    slave_mode = 0;
    idle(1);

    // Write and read from the LSU at the same time: the write must fully finish first.
    ar_first = -1; b_cyc = 0;
    fork
      ls_write(32'h400, 32'h1234_5678, 4'h3);
      ls_read(32'h500);
    join
    chk("t5_write_before_read", ar_first > b_cyc, 1);
    idle(1);

    // Reset in the middle of the read-data phase.
    slave_mode = 3;
    exp_sar_if.push_back(32'h8000_0008);
    if_arvalid = 1; if_araddr = 32'h8000_0008; hs = 0; n = 0;
    while (!hs && n < TMO) begin
      @(negedge clk); hs = if_arvalid && if_arready;
      @(posedge clk); #1; n++;
    end
    if_arvalid = 0;
    if (!hs) chk("t6_ar_timeout", 0, 1);
    if_rready = 1;
    idle(2);
    @(negedge clk);
    chk("t6_in_rdata", {s_rready, grant, busy}, {1'b1, 2'b01, 1'b1});
    #2 rst = 0;
    #1;
    chk("t6_async_drop", {s_rready, grant, busy, if_rvalid}, 0);
    @(posedge clk); #1;
    if_rready = 0; slave_mode = 0;
    idle(2);
    rst = 1;
    idle(2);
    if_read(32'h8000_0004);
    chk("t6_no_replay", exp_if_r.size(), 0);
    idle(1);

    // Randomised concurrent traffic from both masters.
    slave_mode = 1; rnd_rdy = 1;
    fork
      begin
        repeat (30) begin
          idle($urandom_range(2, 0));
          if_read({($urandom_range(3, 0) == 0) ? 4'hE : 4'h8, 12'h0, 14'($urandom), 2'b00});
        end
      end
      begin
        repeat (30) begin
          logic [31:0] a;
          idle($urandom_range(2, 0));
          a = {($urandom_range(3, 0) == 0) ? 4'hE : 4'h1, 12'h0, 14'($urandom), 2'b00};
          if ($urandom_range(1, 0) == 1) ls_write(a, $urandom, 4'($urandom_range(15, 0)));
          else ls_read(a);
        end
      end
    join
    slave_mode = 0; rnd_rdy = 0;
    idle(3);

    chk("end_if_r_left", exp_if_r.size(), 0);
    chk("end_ls_r_left", exp_ls_r.size(), 0);
    chk("end_ls_b_left", exp_ls_b.size(), 0);
    chk("end_sar_left", exp_sar_if.size() + exp_sar_ls.size(), 0);
    chk("end_sw_left", exp_saw.size() + exp_sw.size(), 0);
    chk("end_idle", {grant, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
